// File: rtl/iter_divider_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The master side (requester) drives start and the operands.
// The slave side (divider) returns status and results.
interface iter_divider_if #(
    parameter int LENGTH = 8
);
    logic              start;
    logic [LENGTH-1:0] dividend;
    logic [LENGTH-1:0] divisor;
    logic              busy;
    logic              done;
    logic [LENGTH-1:0] quotient;
    logic [LENGTH-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iter_divider.sv
// Restoring divider that produces one quotient bit per clock.
// A division takes LENGTH cycles in RUN, followed by a single DONE cycle.
// A zero divisor skips RUN and reports quotient = all ones and remainder = dividend.
module iter_divider #(
    parameter int LENGTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     count_reg;
    logic [LENGTH-1:0] divisor_reg;
    // Holds the dividend bits that have not been consumed yet.
    // Quotient bits enter from the LSB end as the dividend bits leave.
    logic [LENGTH-1:0] shift_reg;
    logic [LENGTH-1:0] part_reg;
    logic [LENGTH-1:0] quotient_reg;
    logic [LENGTH-1:0] remainder_reg;
    logic              dbz_reg;

    logic [LENGTH:0]   shifted;
    logic [LENGTH:0]   diff;
    logic              borrow;
    logic [LENGTH-1:0] part_next;
    logic [LENGTH-1:0] shift_next;

    // One restoring step. The partial remainder always stays below the divisor,
    // so a LENGTH+1 bit difference cannot overflow, and bit LENGTH is the borrow.
    always_comb begin
        shifted    = {part_reg, shift_reg[LENGTH-1]};
        diff       = shifted - {1'b0, divisor_reg};
        borrow     = diff[LENGTH];
        part_next  = borrow ? shifted[LENGTH-1:0] : diff[LENGTH-1:0];
        shift_next = {shift_reg[LENGTH-2:0], ~borrow};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration, and result registers. Results change only
    // on the edge that enters DONE and hold until the next such edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            divisor_reg   <= '0;
            shift_reg     <= '0;
            part_reg      <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg   <= bus.dividend;
                        divisor_reg <= bus.divisor;
                        part_reg    <= '0;
                        count_reg   <= '0;
                        dbz_reg     <= (bus.divisor == '0);
                        if (bus.divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                        end
                    end
                end
                RUN: begin
                    shift_reg <= shift_next;
                    part_reg  <= part_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST) begin
                        quotient_reg  <= shift_next;
                        remainder_reg <= part_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (LENGTH = 8).
// A timing-level reference model computes results with plain / and %.
// A compare process checks every output on every falling edge.
// Directed sequences also check hand-computed literal results.
module tb_iter_divider;
    localparam int L = 8;

    logic clk;
    logic rst_n;
    iter_divider_if #(.LENGTH(L)) dif ();

    iter_divider #(.LENGTH(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the number of busy cycles left, a pending result, and the visible result.
    int         m_left = 0;
    bit         m_done = 0;
    logic [7:0] m_q = 0, m_r = 0;
    bit         m_dbz = 0;
    logic [7:0] p_q, p_r;
    logic [7:0] m_a = 0, m_b = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_q = p_q; m_r = p_r;
            end
        end else if (dif.start) begin
            m_a = dif.dividend;
            m_b = dif.divisor;
            if (dif.divisor == 0) begin
                m_q = 8'hFF; m_r = dif.dividend; m_dbz = 1; m_done = 1;
            end else begin
                p_q = dif.dividend / dif.divisor;
                p_r = dif.dividend % dif.divisor;
                m_dbz = 0;
                m_left = L;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", dif.busy, (m_left > 0));
            check("done", dif.done, m_done);
            check("quotient", dif.quotient, m_q);
            check("remainder", dif.remainder, m_r);
            check("div_by_zero", dif.div_by_zero, m_dbz);
            if (dif.done)
                $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0d", m_a, m_b,
                         dif.quotient, dif.remainder, dif.div_by_zero);
        end
    end

    // Wait for done after start was raised at the last falling edge, then check the literals.
    task automatic wait_result(input logic [7:0] dv, input logic [7:0] eq, input logic [7:0] er,
                               input bit edbz, input string name);
        int cyc;
        @(negedge clk);
        dif.start = 0;
        cyc = 0;
        while (!dif.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, (dv == 0) ? 0 : L);
        check({name, " done"}, dif.done, 1);
        check({name, " q"}, dif.quotient, eq);
        check({name, " r"}, dif.remainder, er);
        check({name, " dbz"}, dif.div_by_zero, edbz);
    endtask

    task automatic do_op(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] eq,
                         input logic [7:0] er, input bit edbz, input string name);
        @(negedge clk);
        dif.start = 1; dif.dividend = dd; dif.divisor = dv;
        wait_result(dv, eq, er, edbz, name);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom % 8)
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd255;
            3: return 8'($urandom % 16);
            default: return 8'($urandom % 256);
        endcase
    endfunction

    initial begin
        int cyc;
        rst_n = 0;
        dif.start = 0; dif.dividend = 0; dif.divisor = 0;
        #1;
        check("reset busy", dif.busy, 0);
        check("reset done", dif.done, 0);
        check("reset q", dif.quotient, 0);
        check("reset r", dif.remainder, 0);
        check("reset dbz", dif.div_by_zero, 0);
        cmp_en = 1;

        // start at the first edge after reset release
        @(negedge clk);
        rst_n = 1;
        dif.start = 1; dif.dividend = 200; dif.divisor = 7;
        wait_result(7, 28, 4, 0, "200/7");

        do_op(5, 0, 255, 5, 1, "5/0");
        do_op(9, 3, 3, 0, 0, "9/3");
        do_op(255, 1, 255, 0, 0, "255/1");
        do_op(3, 10, 0, 3, 0, "3/10");
        do_op(255, 255, 1, 0, 0, "255/255");
        do_op(0, 7, 0, 0, 0, "0/7");

        // start held high, operands change mid-run
        @(negedge clk);
        dif.start = 1; dif.dividend = 100; dif.divisor = 9;
        repeat (3) @(negedge clk);
        dif.dividend = 50; dif.divisor = 5;
        cyc = 0;
        while (!dif.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        dif.start = 0;
        check("held done", dif.done, 1);
        check("held q", dif.quotient, 11);
        check("held r", dif.remainder, 1);
        repeat (4) begin
            @(negedge clk);
            check("held no rerun", dif.busy | dif.done, 0);
        end

        // asynchronous reset in the middle of a run
        @(negedge clk);
        dif.start = 1; dif.dividend = 200; dif.divisor = 7;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort busy", dif.busy, 0);
        check("abort done", dif.done, 0);
        check("abort q", dif.quotient, 0);
        check("abort r", dif.remainder, 0);
        check("abort dbz", dif.div_by_zero, 0);
        dif.start = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (12) begin
            @(negedge clk);
            check("no done after reset", dif.done, 0);
        end
        do_op(17, 4, 4, 1, 0, "17/4");

        // random traffic, including starts while busy and zero divisors
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            dif.start = ($urandom % 3 == 0);
            dif.dividend = pick();
            dif.divisor = pick();
        end
        @(negedge clk);
        dif.start = 0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
